// File: rtl/free_list.sv
// Physical-register free list for a 3-wide rename/retire pipeline.
// It is a circular buffer of free tags with three pointers:
//   head        - speculative allocation pointer (advanced by rename)
//   commit_head - allocation pointer as seen by retired instructions
//   tail        - insertion point for tags released at retirement
// A flush rewinds head to commit_head, which returns every speculatively
// allocated tag to the list in a single cycle.
module free_list #(
  parameter int NUM_PREG = 32,
  parameter int NUM_AREG = 8,
  localparam int TW = $clog2(NUM_PREG),
  localparam int NUM_FREE = NUM_PREG - NUM_AREG
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            alloc_en,
  input  logic [2:0]      need_Pw,
  output logic [3*TW-1:0] Pw,
  output logic            stall_FL,
  input  logic [2:0]      ret_valid,
  input  logic [2:0]      ret_has_dest,
  input  logic [3*TW-1:0] Pw_old_ret,
  output logic [TW-1:0]   count_free
);

  logic [TW-1:0] r_buf [NUM_PREG];
  logic [TW-1:0] r_head;
  logic [TW-1:0] r_commit_head;
  logic [TW-1:0] r_tail;

  logic [TW-1:0] w_noff [3];
  logic [TW-1:0] w_koff [3];
  logic [TW-1:0] w_need_cnt;
  logic [TW-1:0] w_ret_cnt;
  logic [2:0]    w_ret_mask;
  logic [2:0]    w_ret_free;
  logic          w_alloc_fire;

  // Compacted slot offsets for allocation and for freeing; a retire slot only
  // counts when every older slot in the group also retires.
  always_comb begin
    w_noff[0]  = '0;
    w_noff[1]  = TW'(need_Pw[0]);
    w_noff[2]  = TW'(need_Pw[0]) + TW'(need_Pw[1]);
    w_need_cnt = w_noff[2] + TW'(need_Pw[2]);

    w_ret_mask = {&ret_valid, &ret_valid[1:0], ret_valid[0]};
    w_ret_free = w_ret_mask & ret_has_dest;

    w_koff[0]  = '0;
    w_koff[1]  = TW'(w_ret_free[0]);
    w_koff[2]  = TW'(w_ret_free[0]) + TW'(w_ret_free[1]);
    w_ret_cnt  = w_koff[2] + TW'(w_ret_free[2]);
  end

  // Occupancy never exceeds NUM_FREE, so the modular difference is exact.
  assign count_free   = r_tail - r_head;
  assign stall_FL     = (count_free < w_need_cnt);
  assign w_alloc_fire = alloc_en & ~stall_FL & ~flush;

  // Offer tags from the speculative head, packed towards slots that need one.
  always_comb begin
    Pw = '0;
    for (int i = 0; i < 3; i++) begin
      Pw[i*TW +: TW] = r_buf[r_head + w_noff[i]];
    end
  end

  // Pointer update: retirement always applies; flush rewinds head past the
  // tags consumed by instructions retiring in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head        <= '0;
      r_commit_head <= '0;
      r_tail        <= TW'(NUM_FREE);
    end else begin
      r_tail        <= r_tail + w_ret_cnt;
      r_commit_head <= r_commit_head + w_ret_cnt;
      if (flush) begin
        r_head <= r_commit_head + w_ret_cnt;
      end else if (w_alloc_fire) begin
        r_head <= r_head + w_need_cnt;
      end
    end
  end

  // Tag storage: reset holds every tag above the architectural mapping;
  // released tags are appended at tail in slot order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_PREG; i++) begin
        r_buf[i] <= (i < NUM_FREE) ? TW'(NUM_AREG + i) : '0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (w_ret_free[i]) begin
          r_buf[r_tail + w_koff[i]] <= Pw_old_ret[i*TW +: TW];
        end
      end
    end
  end

  // Every tag is either free, speculatively owned, or architecturally mapped,
  // so the retired region always spans exactly NUM_FREE entries.
  a_commit_span: assert property (@(posedge clk) disable iff (rst)
    (r_tail - r_commit_head) == TW'(NUM_FREE));

endmodule

// File: tb/tb_free_list.sv
// Directed and model-based bench for the free list.
module tb_free_list;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        alloc_en;
  logic [2:0]  need_Pw;
  logic [14:0] Pw;
  logic        stall_FL;
  logic [2:0]  ret_valid;
  logic [2:0]  ret_has_dest;
  logic [14:0] Pw_old_ret;
  logic [4:0]  count_free;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [2:0] areg;
    logic [4:0] pnew;
    logic [4:0] pold;
  } ent_t;

  ent_t       q[$];
  logic [4:0] spec_map   [8];
  logic [4:0] commit_map [8];

  free_list dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .alloc_en     (alloc_en),
    .need_Pw      (need_Pw),
    .Pw           (Pw),
    .stall_FL     (stall_FL),
    .ret_valid    (ret_valid),
    .ret_has_dest (ret_has_dest),
    .Pw_old_ret   (Pw_old_ret),
    .count_free   (count_free)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [4:0] slot(input int i);
    return Pw[i*5 +: 5];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    flush        = 1'b0;
    alloc_en     = 1'b0;
    need_Pw      = 3'b000;
    ret_valid    = 3'b000;
    ret_has_dest = 3'b000;
    Pw_old_ret   = '0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    #2;
    rst = 1'b0;
    step();
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    need_Pw = 3'b111;
    #1;
    n_checks++;
    if (count_free !== 5'd24) begin
      n_fail++; $display("FAIL reset_count: got %0d want 24", count_free);
    end
    n_checks++;
    if (stall_FL !== 1'b0) begin
      n_fail++; $display("FAIL reset_stall: got %0b want 0", stall_FL);
    end
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (slot(i) !== 5'(8 + i)) begin
        n_fail++; $display("FAIL reset_Pw%0d: got %0d want %0d", i, slot(i), 8 + i);
      end
    end
    #2;
    rst = 1'b0;
    step();
    n_checks++;
    if (count_free !== 5'd24) begin
      n_fail++; $display("FAIL reset_release_count: got %0d want 24", count_free);
    end
  endtask

  task automatic test_alloc_all();
    do_reset();
    need_Pw  = 3'b111;
    alloc_en = 1'b1;
    for (int c = 0; c < 8; c++) begin
      #1;
      for (int i = 0; i < 3; i++) begin
        n_checks++;
        if (slot(i) !== 5'(8 + 3*c + i)) begin
          n_fail++; $display("FAIL alloc_Pw c%0d s%0d: got %0d want %0d", c, i, slot(i), 8 + 3*c + i);
        end
      end
      n_checks++;
      if (count_free !== 5'(24 - 3*c)) begin
        n_fail++; $display("FAIL alloc_count c%0d: got %0d want %0d", c, count_free, 24 - 3*c);
      end
      step();
    end
    n_checks++;
    if (count_free !== 5'd0) begin
      n_fail++; $display("FAIL alloc_empty_count: got %0d want 0", count_free);
    end
    n_checks++;
    if (stall_FL !== 1'b1) begin
      n_fail++; $display("FAIL alloc_empty_stall: got %0b want 1", stall_FL);
    end
    step();
    n_checks++;
    if (count_free !== 5'd0) begin
      n_fail++; $display("FAIL alloc_hold_count: got %0d want 0", count_free);
    end
    idle();
  endtask

  task automatic test_compaction();
    logic [2:0] pat [4];
    int         used;
    int         k;
    pat[0] = 3'b010; pat[1] = 3'b101; pat[2] = 3'b010; pat[3] = 3'b101;
    do_reset();
    alloc_en = 1'b1;
    used = 0;
    for (int c = 0; c < 4; c++) begin
      need_Pw = pat[c];
      #1;
      n_checks++;
      if (count_free !== 5'(24 - used)) begin
        n_fail++; $display("FAIL compact_count c%0d: got %0d want %0d", c, count_free, 24 - used);
      end
      k = 0;
      for (int i = 0; i < 3; i++) begin
        if (pat[c][i]) begin
          n_checks++;
          if (slot(i) !== 5'(8 + used + k)) begin
            n_fail++; $display("FAIL compact_Pw c%0d s%0d: got %0d want %0d", c, i, slot(i), 8 + used + k);
          end
          k++;
        end
      end
      used += k;
      step();
    end
    n_checks++;
    if (count_free !== 5'd18) begin
      n_fail++; $display("FAIL compact_final_count: got %0d want 18", count_free);
    end
    idle();
  endtask

  task automatic test_exhaust_retire();
    do_reset();
    need_Pw  = 3'b111;
    alloc_en = 1'b1;
    repeat (8) step();
    ret_valid    = 3'b111;
    ret_has_dest = 3'b111;
    Pw_old_ret   = {5'd2, 5'd1, 5'd0};
    #1;
    n_checks++;
    if (stall_FL !== 1'b1) begin
      n_fail++; $display("FAIL exh_retire_stall: got %0b want 1", stall_FL);
    end
    step();
    ret_valid = 3'b000;
    #1;
    n_checks++;
    if (count_free !== 5'd3) begin
      n_fail++; $display("FAIL exh_after_count: got %0d want 3", count_free);
    end
    n_checks++;
    if (stall_FL !== 1'b0) begin
      n_fail++; $display("FAIL exh_after_stall: got %0b want 0", stall_FL);
    end
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (slot(i) !== 5'(i)) begin
        n_fail++; $display("FAIL exh_after_Pw%0d: got %0d want %0d", i, slot(i), i);
      end
    end
    idle();
  endtask

  task automatic test_flush();
    logic [4:0] exp_tail [3];
    exp_tail[0] = 5'd30; exp_tail[1] = 5'd31; exp_tail[2] = 5'd5;
    do_reset();
    need_Pw  = 3'b111;
    alloc_en = 1'b1;
    repeat (2) step();
    flush        = 1'b1;
    ret_valid    = 3'b001;
    ret_has_dest = 3'b001;
    Pw_old_ret   = {5'd0, 5'd0, 5'd5};
    #1;
    n_checks++;
    if (count_free !== 5'd18) begin
      n_fail++; $display("FAIL flush_before_count: got %0d want 18", count_free);
    end
    step();
    flush     = 1'b0;
    ret_valid = 3'b000;
    #1;
    n_checks++;
    if (count_free !== 5'd24) begin
      n_fail++; $display("FAIL flush_count: got %0d want 24", count_free);
    end
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (slot(i) !== 5'(9 + i)) begin
        n_fail++; $display("FAIL flush_Pw%0d: got %0d want %0d", i, slot(i), 9 + i);
      end
    end
    repeat (7) step();
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (slot(i) !== exp_tail[i]) begin
        n_fail++; $display("FAIL flush_freed_Pw%0d: got %0d want %0d", i, slot(i), exp_tail[i]);
      end
    end
    idle();
  endtask

  task automatic test_ret_prefix();
    do_reset();
    need_Pw  = 3'b111;
    alloc_en = 1'b1;
    step();
    alloc_en     = 1'b0;
    ret_valid    = 3'b101;
    ret_has_dest = 3'b111;
    Pw_old_ret   = {5'd6, 5'd4, 5'd3};
    step();
    ret_valid = 3'b000;
    #1;
    n_checks++;
    if (count_free !== 5'd22) begin
      n_fail++; $display("FAIL prefix_count: got %0d want 22", count_free);
    end
    alloc_en = 1'b1;
    repeat (7) step();
    alloc_en = 1'b0;
    need_Pw  = 3'b001;
    #1;
    n_checks++;
    if (slot(0) !== 5'd3) begin
      n_fail++; $display("FAIL prefix_freed_tag: got %0d want 3", slot(0));
    end
    n_checks++;
    if (stall_FL !== 1'b0) begin
      n_fail++; $display("FAIL prefix_stall_one: got %0b want 0", stall_FL);
    end
    need_Pw = 3'b011;
    #1;
    n_checks++;
    if (stall_FL !== 1'b1) begin
      n_fail++; $display("FAIL prefix_stall_two: got %0b want 1", stall_FL);
    end
    idle();
  endtask

  task automatic test_wrap_back_to_back();
    int e0;
    do_reset();
    need_Pw      = 3'b111;
    alloc_en     = 1'b1;
    ret_valid    = 3'b111;
    ret_has_dest = 3'b111;
    for (int c = 0; c < 10; c++) begin
      Pw_old_ret = {5'(3*c + 3), 5'(3*c + 2), 5'(3*c + 1)};
      #1;
      e0 = (c < 8) ? (8 + 3*c) : (3*c - 24 + 1);
      n_checks++;
      if (count_free !== 5'd24) begin
        n_fail++; $display("FAIL b2b_count c%0d: got %0d want 24", c, count_free);
      end
      n_checks++;
      if (slot(0) !== 5'(e0)) begin
        n_fail++; $display("FAIL b2b_Pw0 c%0d: got %0d want %0d", c, slot(0), e0);
      end
      step();
    end
    ret_valid = 3'b000;
    #1;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (slot(i) !== 5'(7 + i)) begin
        n_fail++; $display("FAIL wrap_Pw%0d: got %0d want %0d", i, slot(i), 7 + i);
      end
    end
    step();
    n_checks++;
    if (count_free !== 5'd21) begin
      n_fail++; $display("FAIL wrap_after_count: got %0d want 21", count_free);
    end
    n_checks++;
    if (slot(0) !== 5'd10) begin
      n_fail++; $display("FAIL wrap_after_Pw0: got %0d want 10", slot(0));
    end
    idle();
  endtask

  task automatic test_async_reset();
    do_reset();
    need_Pw  = 3'b111;
    alloc_en = 1'b1;
    repeat (2) step();
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if (count_free !== 5'd24) begin
      n_fail++; $display("FAIL async_rst_count: got %0d want 24", count_free);
    end
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (slot(i) !== 5'(8 + i)) begin
        n_fail++; $display("FAIL async_rst_Pw%0d: got %0d want %0d", i, slot(i), 8 + i);
      end
    end
    #2;
    rst = 1'b0;
    step();
    n_checks++;
    if (count_free !== 5'd21) begin
      n_fail++; $display("FAIL async_release_count: got %0d want 21", count_free);
    end
    idle();
  endtask

  task automatic test_random();
    ent_t       e;
    int         nret;
    int         exp_cnt;
    logic       exp_stall;
    logic       fire;
    logic [31:0] owned;
    logic [31:0] offered;
    logic [4:0] t;
    logic [2:0] ar;
    do_reset();
    for (int a = 0; a < 8; a++) begin
      spec_map[a]   = 5'(a);
      commit_map[a] = 5'(a);
    end
    q.delete();
    for (int c = 0; c < 200; c++) begin
      need_Pw  = 3'($urandom_range(0, 7));
      alloc_en = ($urandom_range(0, 3) != 0);
      flush    = ($urandom_range(0, 24) == 0);
      nret     = (q.size() == 0) ? 0 : $urandom_range(0, (q.size() < 3) ? q.size() : 3);
      case (nret)
        0:       ret_valid = ($urandom_range(0, 1) != 0) ? 3'b110 : 3'b000;
        1:       ret_valid = ($urandom_range(0, 1) != 0) ? 3'b101 : 3'b001;
        2:       ret_valid = 3'b011;
        default: ret_valid = 3'b111;
      endcase
      ret_has_dest = 3'b111;
      for (int i = 0; i < 3; i++) begin
        Pw_old_ret[i*5 +: 5] = (i < nret) ? q[i].pold : 5'($urandom_range(0, 31));
      end
      #1;
      exp_cnt   = 24 - q.size();
      exp_stall = (exp_cnt < $countones(need_Pw));
      n_checks++;
      if (count_free !== 5'(exp_cnt)) begin
        n_fail++; $display("FAIL rand_count c%0d: got %0d want %0d", c, count_free, exp_cnt);
      end
      n_checks++;
      if (stall_FL !== exp_stall) begin
        n_fail++; $display("FAIL rand_stall c%0d: got %0b want %0b", c, stall_FL, exp_stall);
      end
      owned = '0;
      for (int a = 0; a < 8; a++) owned[commit_map[a]] = 1'b1;
      for (int k = 0; k < q.size(); k++) owned[q[k].pnew] = 1'b1;
      n_checks++;
      if ($countones(owned) + int'(count_free) != 32) begin
        n_fail++; $display("FAIL rand_union c%0d: got %0d want 32", c, $countones(owned) + int'(count_free));
      end
      fire    = alloc_en && !flush && !exp_stall;
      offered = '0;
      if (fire) begin
        for (int i = 0; i < 3; i++) begin
          if (need_Pw[i]) begin
            t = slot(i);
            n_checks++;
            if (owned[t] || offered[t]) begin
              n_fail++; $display("FAIL rand_dup_tag c%0d s%0d: got tag %0d already in use, want a free tag", c, i, t);
            end
            offered[t] = 1'b1;
            ar     = 3'($urandom_range(0, 7));
            e.areg = ar;
            e.pnew = t;
            e.pold = spec_map[ar];
            spec_map[ar] = t;
            q.push_back(e);
          end
        end
      end
      step();
      for (int k = 0; k < nret; k++) begin
        e = q.pop_front();
        commit_map[e.areg] = e.pnew;
      end
      if (flush) begin
        q.delete();
        for (int a = 0; a < 8; a++) spec_map[a] = commit_map[a];
      end
    end
    idle();
    #1;
    n_checks++;
    if (count_free !== 5'(24 - q.size())) begin
      n_fail++; $display("FAIL rand_final_count: got %0d want %0d", count_free, 24 - q.size());
    end
  endtask

  initial begin
    idle();
    rst = 1'b1;
    test_reset();
    test_alloc_all();
    test_compaction();
    test_exhaust_retire();
    test_flush();
    test_ret_prefix();
    test_wrap_back_to_back();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
